// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
//   Two-stage pipelined ALU with valid/ready handshakes on both sides.
//   Stage 1 (S1) registers the operands and opcode. Stage 2 (S2) registers the
//   result and the CO/OVF/N/Z flags. A carry register (c_acc) chains ADC/SBC
//   onto the previous arithmetic op for multi-word arithmetic. A sticky
//   overflow flag records every delivered beat that had OVF set.
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    operand/op beat valid
//   in_ready    S1 can accept a beat
//   DATA_A      operand A (W bits)
//   DATA_B      operand B (W bits)
//   op          000 AND, 001 OR, 010 ADD, 011 SUB, 100 XOR, 101 ADC, 110 SBC, 111 CMP
//   out_valid   OUT/flags valid
//   out_ready   downstream takes OUT this cycle
//   OUT         result (W bits)
//   CO          carry out (subtract forms: 1 = no borrow)
//   OVF         signed overflow
//   N, Z        OUT[W-1], OUT == 0
//   ovf_sticky  set by any delivered beat with OVF=1
//   clr_sticky  clears ovf_sticky unless a set happens in the same cycle
// -----------------------------------------------------------------------------
module alu_pipe #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] DATA_A,
   input  logic [W-1:0] DATA_B,
   input  logic [2:0]   op,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] OUT,
   output logic         CO,
   output logic         OVF,
   output logic         N,
   output logic         Z,
   output logic         ovf_sticky,
   input  logic         clr_sticky
);

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_ADC = 3'b101;
   localparam logic [2:0] OP_SBC = 3'b110;
   localparam logic [2:0] OP_CMP = 3'b111;

   // Stage 1 registers
   logic         s1_valid_reg;
   logic [W-1:0] s1_a_reg;
   logic [W-1:0] s1_b_reg;
   logic [2:0]   s1_op_reg;

   // Stage 2 registers
   logic         out_valid_reg;
   logic [W-1:0] out_reg;
   logic         co_reg;
   logic         ovf_reg;
   logic         n_reg;
   logic         z_reg;

   logic         c_acc_reg;
   logic         ovf_sticky_reg;

   // Handshake
   logic s2_adv;
   logic s1_adv;
   logic accept;
   logic deliver;

   assign s2_adv   = !out_valid_reg || out_ready;
   assign s1_adv   = s1_valid_reg && s2_adv;
   assign in_ready = !s1_valid_reg || s2_adv;
   assign accept   = in_valid && in_ready;
   assign deliver  = out_valid_reg && out_ready;

   // Bitwise results, one slice per bit
   logic [W-1:0] and_res;
   logic [W-1:0] or_res;
   logic [W-1:0] xor_res;

   genvar gi;
   generate
      for (gi = 0; gi < W; gi++) begin : g_logic
         assign and_res[gi] = s1_a_reg[gi] & s1_b_reg[gi];
         assign or_res[gi]  = s1_a_reg[gi] | s1_b_reg[gi];
         assign xor_res[gi] = s1_a_reg[gi] ^ s1_b_reg[gi];
      end
   endgenerate

   // Arithmetic: every add/subtract form is A + B' + cin, where B' is B or ~B.
   logic [W-1:0] b_eff;
   logic         cin;
   logic         is_arith;
   logic [W:0]   sum;
   logic [W-1:0] res_next;
   logic         co_next;
   logic         ovf_next;

   always_comb begin
      b_eff    = s1_b_reg;
      cin      = 1'b0;
      is_arith = 1'b0;
      unique case (s1_op_reg)
         OP_ADD: begin
            is_arith = 1'b1;
         end
         OP_SUB, OP_CMP: begin
            b_eff    = ~s1_b_reg;
            cin      = 1'b1;
            is_arith = 1'b1;
         end
         OP_ADC: begin
            cin      = c_acc_reg;
            is_arith = 1'b1;
         end
         OP_SBC: begin
            b_eff    = ~s1_b_reg;
            cin      = c_acc_reg;
            is_arith = 1'b1;
         end
         default: begin
         end
      endcase

      sum = {1'b0, s1_a_reg} + {1'b0, b_eff} + {{W{1'b0}}, cin};

      res_next = sum[W-1:0];
      co_next  = sum[W];
      ovf_next = (s1_a_reg[W-1] == b_eff[W-1]) && (sum[W-1] != s1_a_reg[W-1]);

      unique case (s1_op_reg)
         OP_AND: begin
            res_next = and_res;
            co_next  = 1'b0;
            ovf_next = 1'b0;
         end
         OP_OR: begin
            res_next = or_res;
            co_next  = 1'b0;
            ovf_next = 1'b0;
         end
         OP_XOR: begin
            res_next = xor_res;
            co_next  = 1'b0;
            ovf_next = 1'b0;
         end
         default: begin
         end
      endcase
   end

   // Stage 1: when in_ready is high the slot is either empty or draining this
   // cycle, so its next occupancy is simply in_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_reg <= 1'b0;
         s1_a_reg     <= '0;
         s1_b_reg     <= '0;
         s1_op_reg    <= OP_AND;
      end else begin
         if (in_ready) begin
            s1_valid_reg <= in_valid;
         end
         if (accept) begin
            s1_a_reg  <= DATA_A;
            s1_b_reg  <= DATA_B;
            s1_op_reg <= op;
         end
      end
   end

   // Stage 2 and the carry chain. c_acc is written on the same edge the
   // arithmetic beat leaves S1, so a following ADC/SBC already sitting behind
   // it in S1 reads the fresh carry next cycle without any stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_reg <= 1'b0;
         out_reg       <= '0;
         co_reg        <= 1'b0;
         ovf_reg       <= 1'b0;
         n_reg         <= 1'b0;
         z_reg         <= 1'b0;
         c_acc_reg     <= 1'b0;
      end else begin
         if (s2_adv) begin
            out_valid_reg <= s1_valid_reg;
         end
         if (s1_adv) begin
            out_reg <= res_next;
            co_reg  <= co_next;
            ovf_reg <= ovf_next;
            n_reg   <= res_next[W-1];
            z_reg   <= (res_next == '0);
            if (is_arith) begin
               c_acc_reg <= co_next;
            end
         end
      end
   end

   // Sticky overflow: a set on delivery wins over a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_sticky_reg <= 1'b0;
      end else if (deliver && ovf_reg) begin
         ovf_sticky_reg <= 1'b1;
      end else if (clr_sticky) begin
         ovf_sticky_reg <= 1'b0;
      end
   end

   assign out_valid  = out_valid_reg;
   assign OUT        = out_reg;
   assign CO         = co_reg;
   assign OVF        = ovf_reg;
   assign N          = n_reg;
   assign Z          = z_reg;
   assign ovf_sticky = ovf_sticky_reg;

endmodule
